ahblite_busmatrix_arbiter_qos: RTL and testbench
================================================

// Module: ahblite_busmatrix_arbiter_qos
// PURPOSE
//  Registered grant arbiter for one shared bus-matrix slave port (e.g. DTCM) with three masters: SYS, DMA, ACC.
//  Drives the output stage's port select. Fixed priority SYS>DMA>ACC, plus starvation promotion.
//  Holds the grant for the whole of a fixed-length burst.
//  Sits beside the output stage, which muxes master signals on PORT_SEL/PORT_NOSEL and feeds back HREADY/HSEL/HTRANS/HBURST.
// PARAMETERS
//  STARVE_LIMIT  8  accepted slave cycles a requester may wait before promotion; 0 disables promotion
//  CNT_W         4  width of each wait counter; must hold STARVE_LIMIT
// PORTS
//  HCLK                 in   1  clock; the single clock of the block
//  HRESET               in   1  reset, synchronous, active-high
//  REQ_SYS              in   1  SYS request (TRANS_HOLD & HSEL from the input stage)
//  REQ_DMA              in   1  DMA request
//  REQ_ACC              in   1  ACC request
//  HREADY               in   1  output-stage HREADY; arbitration advances only when it is 1
//  HSEL                 in   1  output-stage HSEL (muxed from the owner)
//  HTRANS               in   2  output-stage HTRANS
//  HBURST               in   3  output-stage HBURST
//  PORT_SEL             out  2  owner: 01 SYS, 10 DMA, 11 ACC, 00 none
//  PORT_NOSEL           out  1  1 = no owner; output stage drives an idle bus
//  BURST_LOCK           out  1  1 = grant locked inside a fixed-length burst (debug/perf)
// BEHAVIOUR
//  Reset: PORT_SEL=00, PORT_NOSEL=1, BURST_LOCK=0, beats_left=0, all wait counters=0, state IDLE.
//  - Reset applies whatever HREADY is, including mid-burst.
//  accepted = HREADY & HSEL & HTRANS[1] (NONSEQ or SEQ).
//  States:
//  - IDLE (no owner).
//  - GRANT (owner, unlocked).
//  - BURST (owner, locked).
//  All state, PORT_SEL, PORT_NOSEL and counters change only on a HCLK edge with HREADY=1. With HREADY=0 everything holds.
//  Winner = starved requester first (wait==STARVE_LIMIT, tie broken SYS>DMA>ACC). Otherwise the highest-priority asserted REQ.
//  Arbitration point (HREADY=1), in IDLE or GRANT:
//  - Load winner; GRANT if any REQ, else IDLE.
//  - The owner is pre-empted whenever it is not the winner; the grant is not sticky.
//  Burst entry: in GRANT or BURST, an accepted NONSEQ with HBURST in {010..111} ->
//  - BURST, beats_left = len-1.
//  - len is 4 for WRAP4/INCR4, 8 for WRAP8/INCR8, 16 for WRAP16/INCR16.
//  In BURST:
//  - Accepted SEQ decrements beats_left. When the result is 0 -> arbitration point on the same edge.
//  - BUSY does not decrement and holds the lock.
//  - Early termination: accepted NONSEQ re-enters via the burst-entry rule.
//  - Early termination: HTRANS=IDLE with HREADY=1 -> lock cleared and arbitration at once.
//  - The owner dropping REQ while locked does not break the lock; only the HTRANS rules above do.
//  SINGLE and INCR (000/001) never lock; INCR may be re-arbitrated at any beat.
//  Starvation promotion never breaks a BURST lock.
//  Latency: REQ rising in IDLE -> PORT_SEL valid on the next HCLK edge (1 cycle). Grant change takes effect on the edge after the arbitration point.
//  Wait counters, per master, on each HREADY=1 edge:
//  - +1 if REQ_x=1 and the owner is not x; saturates at STARVE_LIMIT.
//  - Cleared when x is granted or REQ_x=0.
//  - Held while HREADY=0.
//  PORT_NOSEL = (state==IDLE). PORT_SEL=00 whenever PORT_NOSEL=1. BURST_LOCK = (state==BURST).
//  Simultaneous events:
//  - Burst entry beats an arbitration point from the same accepted beat.
//  - Reset beats everything.
// STRUCTURE
//  Shared package ahb_bm_pkg:
//  - HTRANS codes (IDLE/BUSY/NONSEQ/SEQ).
//  - HBURST codes.
//  - Port encodings PORT_SYS/PORT_DMA/PORT_ACC/PORT_NONE.
//  - Function burst_len(hburst) returning 0 for unlocked bursts.
//  One sub-module ahb_bm_wait_counter (saturating wait counter plus starved flag), instantiated three times.
//  Winner logic and the state machine stay in the top module.
// TESTING
//  1. Reset, then REQ_DMA=1 -> next edge PORT_SEL=10, PORT_NOSEL=0; drop REQ_DMA -> PORT_NOSEL=1, PORT_SEL=00.
//  2. REQ_SYS=REQ_DMA=REQ_ACC=1 in the same cycle, STARVE_LIMIT=0 -> PORT_SEL=01 held while SYS requests.
//  3. ACC INCR8 (NONSEQ + 7 SEQ, two wait states); SYS requests from beat 2 ->
//     - ACC is held and BURST_LOCK=1 for 8 accepted beats.
//     - PORT_SEL=01 on the edge after beat 8.
//  4. STARVE_LIMIT=3, SYS streams SINGLE with REQ_DMA=1 -> DMA granted after its counter hits 3 accepted cycles; counter then reads 0.
//  5. DMA WRAP4 terminated with IDLE after 2 beats, SYS requesting -> lock clears and PORT_SEL=01 on the next HREADY edge.
//  6. HRESET asserted mid-INCR16 while HREADY=0 -> next edge PORT_NOSEL=1, BURST_LOCK=0, counters 0.

Source files
------------

// File: rtl/ahb_bm_pkg.sv
// Shared AHB-Lite bus-matrix definitions: transfer/burst codes, port-select
// encodings, arbiter state encoding and burst-length decode.
package ahb_bm_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam logic [1:0] PORT_NONE = 2'b00;
    localparam logic [1:0] PORT_SYS  = 2'b01;
    localparam logic [1:0] PORT_DMA  = 2'b10;
    localparam logic [1:0] PORT_ACC  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GRANT = 2'b01,
        ST_BURST = 2'b10
    } arb_state_e;

    // Fixed-length bursts return their beat count; SINGLE/INCR return 0 (never lock).
    function automatic logic [4:0] burst_len(input logic [2:0] hburst);
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  burst_len = 5'd4;
            HBURST_WRAP8,  HBURST_INCR8:  burst_len = 5'd8;
            HBURST_WRAP16, HBURST_INCR16: burst_len = 5'd16;
            default:                      burst_len = 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_bm_wait_counter.sv
// Per-master saturating wait counter; flags the master as starved once it has
// waited LIMIT arbitration cycles without being granted.
module ahb_bm_wait_counter
    import ahb_bm_pkg::*;
#(
    parameter int LIMIT = 8,
    parameter int CNT_W = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic adv,
    input  logic req,
    input  logic granted,
    output logic starved
);

    localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (adv) begin
            if (!req || granted) begin
                cnt <= '0;
            end else if (cnt != LIM) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // LIMIT of 0 disables promotion entirely.
    assign starved = (LIMIT != 0) && (cnt == LIM);

endmodule

// File: rtl/ahblite_busmatrix_arbiter_qos.sv
// Registered three-master grant arbiter for one shared bus-matrix slave port:
// fixed priority SYS>DMA>ACC with starvation promotion and fixed-burst locking.
module ahblite_busmatrix_arbiter_qos
    import ahb_bm_pkg::*;
#(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 4
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       REQ_SYS,
    input  logic       REQ_DMA,
    input  logic       REQ_ACC,
    input  logic       HREADY,
    input  logic       HSEL,
    input  logic [1:0] HTRANS,
    input  logic [2:0] HBURST,
    output logic [1:0] PORT_SEL,
    output logic       PORT_NOSEL,
    output logic       BURST_LOCK
);

    arb_state_e state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] beats_q, beats_d;
    logic [1:0] winner;
    logic [4:0] blen;
    logic       accepted;
    logic       arbitrate;
    logic       starved_sys, starved_dma, starved_acc;

    ahb_bm_wait_counter #(.LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)) u_wait_sys (
        .clk(HCLK), .rst(HRESET), .adv(HREADY), .req(REQ_SYS),
        .granted((sel_q == PORT_SYS) || (sel_d == PORT_SYS)), .starved(starved_sys)
    );
    ahb_bm_wait_counter #(.LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)) u_wait_dma (
        .clk(HCLK), .rst(HRESET), .adv(HREADY), .req(REQ_DMA),
        .granted((sel_q == PORT_DMA) || (sel_d == PORT_DMA)), .starved(starved_dma)
    );
    ahb_bm_wait_counter #(.LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)) u_wait_acc (
        .clk(HCLK), .rst(HRESET), .adv(HREADY), .req(REQ_ACC),
        .granted((sel_q == PORT_ACC) || (sel_d == PORT_ACC)), .starved(starved_acc)
    );

    // A starved master only counts while it is still requesting.
    always_comb begin
        winner = PORT_NONE;
        if (starved_sys && REQ_SYS)      winner = PORT_SYS;
        else if (starved_dma && REQ_DMA) winner = PORT_DMA;
        else if (starved_acc && REQ_ACC) winner = PORT_ACC;
        else if (REQ_SYS)                winner = PORT_SYS;
        else if (REQ_DMA)                winner = PORT_DMA;
        else if (REQ_ACC)                winner = PORT_ACC;
    end

    assign accepted = HSEL && HTRANS[1];
    assign blen     = burst_len(HBURST);

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        beats_d   = beats_q;
        arbitrate = 1'b0;
        if (HREADY) begin
            // Burst entry takes precedence over any arbitration on the same beat.
            if (state_q != ST_IDLE && accepted && HTRANS == HTRANS_NONSEQ && blen != 5'd0) begin
                state_d = ST_BURST;
                beats_d = 4'(blen - 5'd1);
            end else if (state_q == ST_BURST) begin
                if (accepted && HTRANS == HTRANS_SEQ) begin
                    beats_d   = beats_q - 4'd1;
                    arbitrate = (beats_q == 4'd1);
                end else if (HTRANS == HTRANS_IDLE || (accepted && HTRANS == HTRANS_NONSEQ)) begin
                    arbitrate = 1'b1;
                end
            end else begin
                arbitrate = 1'b1;
            end
            if (arbitrate) begin
                sel_d   = winner;
                state_d = (winner == PORT_NONE) ? ST_IDLE : ST_GRANT;
                beats_d = 4'd0;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= ST_IDLE;
            sel_q   <= PORT_NONE;
            beats_q <= 4'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            beats_q <= beats_d;
        end
    end

    assign PORT_SEL   = sel_q;
    assign PORT_NOSEL = (state_q == ST_IDLE);
    assign BURST_LOCK = (state_q == ST_BURST);

endmodule

// File: tb/tb_ahblite_busmatrix_arbiter_qos.sv
// Bench for the QoS bus-matrix arbiter: three instances (STARVE_LIMIT 0, 3, 8)
// share one stimulus stream and are checked each cycle against a behavioural model.
module tb_ahblite_busmatrix_arbiter_qos;

    logic       clk = 1'b0;
    logic       rst, rs, rd, ra, hready, hsel;
    logic [1:0] htrans;
    logic [2:0] hburst;

    logic [1:0] sel0, sel1, sel2;
    logic       nosel0, nosel1, nosel2, lock0, lock1, lock2;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    ahblite_busmatrix_arbiter_qos #(.STARVE_LIMIT(0), .CNT_W(4)) d0 (
        .HCLK(clk), .HRESET(rst), .REQ_SYS(rs), .REQ_DMA(rd), .REQ_ACC(ra),
        .HREADY(hready), .HSEL(hsel), .HTRANS(htrans), .HBURST(hburst),
        .PORT_SEL(sel0), .PORT_NOSEL(nosel0), .BURST_LOCK(lock0));
    ahblite_busmatrix_arbiter_qos #(.STARVE_LIMIT(3), .CNT_W(4)) d3 (
        .HCLK(clk), .HRESET(rst), .REQ_SYS(rs), .REQ_DMA(rd), .REQ_ACC(ra),
        .HREADY(hready), .HSEL(hsel), .HTRANS(htrans), .HBURST(hburst),
        .PORT_SEL(sel1), .PORT_NOSEL(nosel1), .BURST_LOCK(lock1));
    ahblite_busmatrix_arbiter_qos #(.STARVE_LIMIT(8), .CNT_W(4)) d8 (
        .HCLK(clk), .HRESET(rst), .REQ_SYS(rs), .REQ_DMA(rd), .REQ_ACC(ra),
        .HREADY(hready), .HSEL(hsel), .HTRANS(htrans), .HBURST(hburst),
        .PORT_SEL(sel2), .PORT_NOSEL(nosel2), .BURST_LOCK(lock2));

    logic [1:0] sel_a   [3];
    logic       nosel_a [3];
    logic       lock_a  [3];
    logic [3:0] cnt_a   [3][3];

    assign sel_a[0] = sel0;   assign sel_a[1] = sel1;   assign sel_a[2] = sel2;
    assign nosel_a[0] = nosel0; assign nosel_a[1] = nosel1; assign nosel_a[2] = nosel2;
    assign lock_a[0] = lock0; assign lock_a[1] = lock1; assign lock_a[2] = lock2;
    assign cnt_a[0][0] = d0.u_wait_sys.cnt;
    assign cnt_a[0][1] = d0.u_wait_dma.cnt;
    assign cnt_a[0][2] = d0.u_wait_acc.cnt;
    assign cnt_a[1][0] = d3.u_wait_sys.cnt;
    assign cnt_a[1][1] = d3.u_wait_dma.cnt;
    assign cnt_a[1][2] = d3.u_wait_acc.cnt;
    assign cnt_a[2][0] = d8.u_wait_sys.cnt;
    assign cnt_a[2][1] = d8.u_wait_dma.cnt;
    assign cnt_a[2][2] = d8.u_wait_acc.cnt;

    // Behavioural model: owner 0 = none, 1 = SYS, 2 = DMA, 3 = ACC.
    int lim [3] = '{0, 3, 8};
    int m_own   [3];
    bit m_lock  [3];
    int m_beats [3];
    int m_wait  [3][3];

    task automatic model_step(input int k);
        int  len, win, hb;
        bit  acc, arb;
        bit  r [3];
        r[0] = rs; r[1] = rd; r[2] = ra;
        if (rst) begin
            m_own[k] = 0; m_lock[k] = 0; m_beats[k] = 0;
            for (int x = 0; x < 3; x++) m_wait[k][x] = 0;
            return;
        end
        if (!hready) return;
        hb  = int'(hburst);
        len = (hb >= 2) ? (4 << ((hb - 2) / 2)) : 0;
        acc = hsel && (htrans >= 2);
        arb = 0;
        if (m_own[k] != 0 && acc && htrans == 2 && len != 0) begin
            m_lock[k] = 1; m_beats[k] = len - 1;
        end else if (m_lock[k]) begin
            if (acc && htrans == 3) begin
                m_beats[k] = m_beats[k] - 1;
                if (m_beats[k] == 0) arb = 1;
            end else if (htrans == 0 || (acc && htrans == 2)) begin
                arb = 1;
            end
        end else begin
            arb = 1;
        end
        win = m_own[k];
        if (arb) begin
            m_lock[k] = 0;
            win = 0;
            for (int x = 2; x >= 0; x--) if (r[x]) win = x + 1;
            if (lim[k] > 0)
                for (int x = 2; x >= 0; x--) if (r[x] && m_wait[k][x] == lim[k]) win = x + 1;
        end
        for (int x = 0; x < 3; x++) begin
            if (!r[x] || m_own[k] == x + 1 || win == x + 1) m_wait[k][x] = 0;
            else if (m_wait[k][x] < lim[k]) m_wait[k][x] = m_wait[k][x] + 1;
        end
        m_own[k] = win;
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) model_step(k);
    end

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("model_sel[%0d]", k), int'(sel_a[k]), m_own[k]);
                check($sformatf("model_nosel[%0d]", k), int'(nosel_a[k]), int'(m_own[k] == 0));
                check($sformatf("model_lock[%0d]", k), int'(lock_a[k]), int'(m_lock[k]));
                for (int x = 0; x < 3; x++)
                    check($sformatf("model_wait[%0d][%0d]", k, x), int'(cnt_a[k][x]), m_wait[k][x]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit s, input bit d, input bit a, input bit rdy,
                         input bit hs, input logic [1:0] tr, input logic [2:0] bu);
        rs = s; rd = d; ra = a; hready = rdy; hsel = hs; htrans = tr; hburst = bu;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 1, 0, 2'b00, 3'b000);
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        check("reset_sel", int'(sel2), 0);
        check("reset_nosel", int'(nosel2), 1);
        check("reset_lock", int'(lock2), 0);

        // Single DMA request: granted next edge, released when it drops.
        drive(0, 1, 0, 1, 0, 2'b00, 3'b000); tick();
        check("dma_grant_sel", int'(sel2), 2);
        check("dma_grant_nosel", int'(nosel2), 0);
        drive(0, 0, 0, 1, 0, 2'b00, 3'b000); tick();
        check("dma_release_nosel", int'(nosel2), 1);
        check("dma_release_sel", int'(sel2), 0);

        // All three request together, promotion disabled: SYS keeps it.
        drive(1, 1, 1, 1, 0, 2'b00, 3'b000); tick();
        check("prio_first_sel", int'(sel0), 1);
        repeat (5) tick();
        check("prio_held_sel", int'(sel0), 1);

        // ACC INCR8 with two wait states; SYS requests from beat 2.
        drive(0, 0, 0, 1, 0, 2'b00, 3'b000); tick();
        drive(0, 0, 1, 1, 0, 2'b00, 3'b000); tick();
        check("acc_grant_sel", int'(sel0), 3);
        drive(0, 0, 1, 1, 1, 2'b10, 3'b101); tick();
        check("incr8_lock", int'(lock0), 1);
        drive(1, 0, 1, 1, 1, 2'b11, 3'b101); tick();
        hready = 0; tick();
        check("incr8_wait_sel", int'(sel0), 3);
        hready = 1; tick(); tick();
        hready = 0; tick();
        hready = 1; tick(); tick(); tick();
        check("incr8_beat7_sel", int'(sel0), 3);
        check("incr8_beat7_lock", int'(lock0), 1);
        tick();
        check("incr8_end_sel", int'(sel0), 1);
        check("incr8_end_lock", int'(lock0), 0);

        // STARVE_LIMIT=3: DMA promoted over streaming SYS singles.
        drive(0, 0, 0, 1, 0, 2'b00, 3'b000); tick();
        drive(1, 1, 0, 1, 1, 2'b10, 3'b000); tick();
        check("starve_c1_sel", int'(sel1), 1);
        check("starve_c1_wait", int'(cnt_a[1][1]), 1);
        tick(); tick();
        check("starve_c3_wait", int'(cnt_a[1][1]), 3);
        check("starve_c3_sel", int'(sel1), 1);
        tick();
        check("starve_promoted_sel", int'(sel1), 2);
        check("starve_promoted_wait", int'(cnt_a[1][1]), 0);

        // DMA WRAP4 cut short by IDLE after two beats while SYS requests.
        drive(0, 0, 0, 1, 0, 2'b00, 3'b000); tick();
        drive(0, 1, 0, 1, 0, 2'b00, 3'b000); tick();
        check("wrap4_grant_sel", int'(sel0), 2);
        drive(1, 1, 0, 1, 1, 2'b10, 3'b010); tick();
        check("wrap4_lock", int'(lock0), 1);
        check("wrap4_lock_sel", int'(sel0), 2);
        htrans = 2'b11; tick();
        check("wrap4_beat2_lock", int'(lock0), 1);
        htrans = 2'b00; tick();
        check("wrap4_idle_lock", int'(lock0), 0);
        check("wrap4_idle_sel", int'(sel0), 1);

        // Reset mid-INCR16 with HREADY low.
        drive(0, 0, 0, 1, 0, 2'b00, 3'b000); tick();
        drive(0, 1, 1, 1, 0, 2'b00, 3'b000); tick();
        drive(0, 1, 1, 1, 1, 2'b10, 3'b111); tick();
        htrans = 2'b11; tick();
        check("incr16_lock", int'(lock2), 1);
        check("incr16_acc_wait", int'(cnt_a[2][2]), 3);
        hready = 0; rst = 1; tick();
        check("rst_mid_nosel", int'(nosel2), 1);
        check("rst_mid_lock", int'(lock2), 0);
        check("rst_mid_sel", int'(sel2), 0);
        check("rst_mid_acc_wait", int'(cnt_a[2][2]), 0);
        check("rst_mid_dma_wait", int'(cnt_a[2][1]), 0);
        rst = 0;

        // Randomised traffic checked against the model every cycle.
        for (int i = 0; i < 4000; i++) begin
            int t;
            rs = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            ra = 1'($urandom_range(0, 1));
            hready = ($urandom_range(0, 9) < 8);
            hsel   = ($urandom_range(0, 19) < 17);
            t = $urandom_range(0, 9);
            htrans = (t < 5) ? 2'b11 : (t < 6) ? 2'b01 : (t < 8) ? 2'b10 : 2'b00;
            hburst = 3'($urandom_range(0, 7));
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
